// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester indices and default geometry of the data memory.
package dmem_arb_pkg;

   localparam int DEF_DEPTH  = 100;
   localparam int DEF_ADDR_W = 7;
   localparam int DEF_LEN_W  = 4;
   localparam int DEF_DATA_W = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // Requester indices; also the encoding of the owner and last-grant flags.
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the two requesters.
// Macro DMEM_ARB_FIXED_PRIO_EN: when defined M0 wins every tie and the
// last-grant input disappears; otherwise ties alternate round-robin.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic m0_req,
   input  logic m1_req,
`ifndef DMEM_ARB_FIXED_PRIO_EN
   input  logic last,
`endif
   output logic valid,
   output logic win
);

   // Pick a single requester; on a tie apply the configured priority rule.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      valid = m0_req | m1_req;
      win   = M0;
      if (m0_req && m1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
         win = M0;
`else
         win = (last == M0) ? M1 : M0;
`endif
      end else if (m1_req) begin
         win = M1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester burst arbiter in front of the single-port data memory.
// A granted requester gets 1..16 consecutive word beats, one per cycle, with
// the address generated here and wrapped at DEPTH. Dropping req mid-burst
// abandons the remaining beats. Macro DMEM_ARB_FIXED_PRIO_EN selects fixed
// M0 priority on ties instead of round-robin.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = DEF_LEN_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [LEN_W-1:0]  m0_len,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_ack,
   output logic              m0_done,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [LEN_W-1:0]  m1_len,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_ack,
   output logic              m1_done,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rd
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t             state_q, state_d;
   logic               owner_q, owner_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [LEN_W-1:0]   remain_q, remain_d;
   logic               dir_q, dir_d;

   logic               pick_valid;
   logic               pick_win;
   logic               owner_req;
   logic               in_burst;
   logic               beat;
   logic               last_beat;

`ifndef DMEM_ARB_FIXED_PRIO_EN
   logic               last_q, last_d;
`endif

   dmem_arb_pick u_pick (
      .m0_req (m0_req),
      .m1_req (m1_req),
`ifndef DMEM_ARB_FIXED_PRIO_EN
      .last   (last_q),
`endif
      .valid  (pick_valid),
      .win    (pick_win)
   );

   // A beat happens only while the owner still holds its request.
   always_comb begin
      in_burst  = (state_q == BURST);
      owner_req = (owner_q == M1) ? m1_req : m0_req;
      beat      = in_burst && owner_req;
      last_beat = beat && (remain_q == '0);
   end

   // Sequence the burst: latch the winner's command in IDLE, step per beat.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      dir_d    = dir_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_d   = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d  = BURST;
               owner_d  = pick_win;
               addr_d   = (pick_win == M1) ? m1_addr : m0_addr;
               remain_d = (pick_win == M1) ? m1_len  : m0_len;
               dir_d    = (pick_win == M1) ? m1_we   : m0_we;
`ifndef DMEM_ARB_FIXED_PRIO_EN
               last_d   = pick_win;
`endif
            end
         end
         BURST: begin
            if (!owner_req || last_beat) begin
               state_d = IDLE;
            end else begin
               // Out-of-range base addresses also fold back to word 0 here.
               addr_d   = (addr_q >= LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
               remain_d = remain_q - LEN_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any burst in flight.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst) begin
         state_q  <= IDLE;
         owner_q  <= M0;
         addr_q   <= '0;
         remain_q <= '0;
         dir_q    <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         last_q   <= M1;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         dir_q    <= dir_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         last_q   <= last_d;
`endif
      end
   end

   // Decode grants, beat handshakes and memory pins from state and owner req.
   always_comb begin
      m0_gnt  = in_burst && (owner_q == M0);
      m1_gnt  = in_burst && (owner_q == M1);
      m0_ack  = beat && (owner_q == M0);
      m1_ack  = beat && (owner_q == M1);
      m0_done = last_beat && (owner_q == M0);
      m1_done = last_beat && (owner_q == M1);
      mem_a   = in_burst ? addr_q : '0;
      mem_we  = beat && dir_q;
      mem_wd  = '0;
      if (in_burst) begin
         mem_wd = (owner_q == M1) ? m1_wdata : m0_wdata;
      end
      rdata   = (beat && !dir_q) ? mem_rd : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. A bench-side memory stands in for the
// real data memory; an expected-beat queue plus a shadow memory predict every
// acknowledged beat, and directed scenarios pin grant timing and read data.
module tb_dmem_arbiter;

   localparam int DEPTH = 100;
   localparam int PERIOD = 10;
`ifdef DMEM_ARB_FIXED_PRIO_EN
   localparam int TIE3_FIRST = 0;
`else
   localparam int TIE3_FIRST = 1;
`endif

   typedef struct {
      int          m;
      bit          we;
      int          addr;
      logic [31:0] wd;
      bit          done;
   } beat_t;

   logic        clk;
   logic        rst;
   logic        m_req   [2];
   logic        m_we    [2];
   logic [6:0]  m_addr  [2];
   logic [3:0]  m_len   [2];
   logic [31:0] m_wdata [2];
   logic        m_gnt   [2];
   logic        m_ack   [2];
   logic        m_done  [2];
   logic [31:0] rdata;
   logic [6:0]  mem_a;
   logic [31:0] mem_wd;
   logic        mem_we;
   logic [31:0] mem_rd;

   logic [31:0] mem       [DEPTH];
   logic [31:0] model_mem [DEPTH];
   beat_t       exp_q[$];

   int checks = 0;
   int failures = 0;

   dmem_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .m0_req   (m_req[0]),
      .m0_we    (m_we[0]),
      .m0_addr  (m_addr[0]),
      .m0_len   (m_len[0]),
      .m0_wdata (m_wdata[0]),
      .m0_gnt   (m_gnt[0]),
      .m0_ack   (m_ack[0]),
      .m0_done  (m_done[0]),
      .m1_req   (m_req[1]),
      .m1_we    (m_we[1]),
      .m1_addr  (m_addr[1]),
      .m1_len   (m_len[1]),
      .m1_wdata (m_wdata[1]),
      .m1_gnt   (m_gnt[1]),
      .m1_ack   (m_ack[1]),
      .m1_done  (m_done[1]),
      .rdata    (rdata),
      .mem_a    (mem_a),
      .mem_wd   (mem_wd),
      .mem_we   (mem_we),
      .mem_rd   (mem_rd)
   );

   initial begin
      clk = 1'b0;
      forever #(PERIOD / 2) clk = ~clk;
   end

   // Stand-in data memory: async read, sync write, out-of-range ignored.
   assign mem_rd = (int'(mem_a) < DEPTH) ? mem[mem_a] : 32'h0;
   always @(posedge clk) begin
      if (mem_we && int'(mem_a) < DEPTH) mem[mem_a] <= mem_wd;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Burst address rule: step by one, any address at or past the end goes to 0.
   function automatic int next_addr(input int a);
      return (a + 1 >= DEPTH) ? 0 : a + 1;
   endfunction

   function automatic void push_burst(input int m, input bit we, input int addr, input int len,
                                      input logic [31:0] wd0, input int nbeats);
      int a = addr;
      for (int i = 0; i < nbeats; i++) begin
         exp_q.push_back('{m: m, we: we, addr: a, wd: wd0 + 32'(i), done: (i == len)});
         a = next_addr(a);
      end
   endfunction

   // Every cycle: each acknowledged beat must match the next predicted beat.
   always @(negedge clk) begin
      if (rst) begin
         beat_t e;
         logic [31:0] exp_rd;
         check("we_without_ack", mem_we & ~(m_ack[0] | m_ack[1]), 1'b0);
         check("done_without_ack", (m_done[0] & ~m_ack[0]) | (m_done[1] & ~m_ack[1]), 1'b0);
         check("double_gnt", m_gnt[0] & m_gnt[1], 1'b0);
         if (m_ack[0] || m_ack[1]) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", {m_ack[1], m_ack[0]}, 2'b00);
            end else begin
               e = exp_q.pop_front();
               exp_rd = 32'h0;
               if (!e.we && e.addr < DEPTH) exp_rd = model_mem[e.addr];
               check("beat_master", {m_ack[1], m_ack[0]}, (e.m == 1) ? 2'b10 : 2'b01);
               check("beat_gnt", m_gnt[e.m], 1'b1);
               check("beat_addr", mem_a, e.addr);
               check("beat_we", mem_we, e.we);
               if (e.we) check("beat_wdata", mem_wd, e.wd);
               check("beat_done", m_done[e.m], e.done);
               check("beat_rdata", rdata, exp_rd);
               if (e.we && e.addr < DEPTH) model_mem[e.addr] = e.wd;
            end
         end
      end
   end

   // Drive one burst from requester m; entered and left at posedge+1.
   task automatic burst(input int m, input bit we, input int addr, input int len,
                        input logic [31:0] wd0, input int drop_after,
                        output longint t_gnt, output int lat, output logic [15:0][31:0] rd);
      int beats = 0;
      bit done_seen = 0;
      int guard = 0;
      rd = '0;
      lat = 0;
      t_gnt = 0;
      m_we[m] = we;
      m_addr[m] = 7'(addr);
      m_len[m] = 4'(len);
      m_wdata[m] = wd0;
      m_req[m] = 1'b1;
      @(negedge clk);
      while (!m_gnt[m] && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      if (!m_gnt[m]) begin
         check("gnt_timeout", m_gnt[m], 1'b1);
         m_req[m] = 1'b0;
         @(posedge clk);
         #1;
         return;
      end
      t_gnt = $time;
      forever begin
         if (m_ack[m]) begin
            if (beats < 16) rd[beats] = rdata;
            beats++;
            if (m_done[m]) done_seen = 1;
         end
         guard++;
         @(posedge clk);
         #1;
         if (done_seen || beats == drop_after || guard > 40) begin
            m_req[m] = 1'b0;
            break;
         end
         m_wdata[m] = wd0 + 32'(beats);
         @(negedge clk);
      end
      check("burst_end", done_seen || beats == drop_after, 1'b1);
   endtask

   // Both requesters ask together: M0 reads a0 (2 beats), M1 writes a1 (2 beats).
   task automatic tie(input int first, input int a0, input int a1, input logic [31:0] w1);
      longint t0, t1;
      int lat0, lat1;
      logic [15:0][31:0] rd0, rd1;
      if (first == 0) begin
         push_burst(0, 1'b0, a0, 1, 32'h0, 2);
         push_burst(1, 1'b1, a1, 1, w1, 2);
      end else begin
         push_burst(1, 1'b1, a1, 1, w1, 2);
         push_burst(0, 1'b0, a0, 1, 32'h0, 2);
      end
      fork
         burst(0, 1'b0, a0, 1, 32'h0, -1, t0, lat0, rd0);
         burst(1, 1'b1, a1, 1, w1, -1, t1, lat1, rd1);
      join
      // Winner's 2-beat burst, one idle cycle, then the loser: 3 cycles apart.
      if (first == 0) begin
         check("tie_order_gap", 64'(t1 - t0), 64'(3 * PERIOD));
         check("tie_winner_lat", lat0, 1);
      end else begin
         check("tie_order_gap", 64'(t0 - t1), 64'(3 * PERIOD));
         check("tie_winner_lat", lat1, 1);
      end
   endtask

   initial begin
      longint t;
      int lat;
      int acks;
      int n;
      logic [15:0][31:0] rd;

      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = 32'h0;
         model_mem[i] = 32'h0;
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_req[i] = 1'b0;
         m_we[i] = 1'b0;
         m_addr[i] = '0;
         m_len[i] = '0;
         m_wdata[i] = '0;
      end

      // Pin the model's address rule.
      check("model_next_5", next_addr(5), 6);
      check("model_next_99", next_addr(99), 0);
      check("model_next_120", next_addr(120), 0);

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_m0_gnt", m_gnt[0], 1'b0);
      check("rst_m1_gnt", m_gnt[1], 1'b0);
      check("rst_acks", {m_ack[1], m_ack[0], m_done[1], m_done[0]}, 4'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_a", mem_a, 7'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Ties: first after reset goes to M0, then M1 (granted last) loses next.
      tie(0, 10, 12, 32'hC0);
      tie(0, 12, 14, 32'hC8);
      push_burst(0, 1'b0, 14, 0, 32'h0, 1);
      burst(0, 1'b0, 14, 0, 32'h0, -1, t, lat, rd);
      check("rd_m0_14", rd[0], 32'hC8);
      // Last grant was M0: round-robin hands the tie to M1, fixed priority to M0.
      tie(TIE3_FIRST, 30, 32, 32'hCC);

      // M1 write burst to 5..8, then M0 reads it back.
      push_burst(1, 1'b1, 5, 3, 32'hA0, 4);
      burst(1, 1'b1, 5, 3, 32'hA0, -1, t, lat, rd);
      check("m1_wr_lat", lat, 1);
      @(negedge clk);
      check("m1_gnt_after_done", m_gnt[1], 1'b0);
      @(posedge clk);
      #1;
      push_burst(0, 1'b0, 5, 3, 32'h0, 4);
      burst(0, 1'b0, 5, 3, 32'h0, -1, t, lat, rd);
      check("rd_5", rd[0], 32'hA0);
      check("rd_6", rd[1], 32'hA1);
      check("rd_7", rd[2], 32'hA2);
      check("rd_8", rd[3], 32'hA3);

      // Wrap at the top of memory.
      push_burst(0, 1'b1, 98, 3, 32'hD0, 4);
      burst(0, 1'b1, 98, 3, 32'hD0, -1, t, lat, rd);
      push_burst(0, 1'b0, 98, 3, 32'h0, 4);
      burst(0, 1'b0, 98, 3, 32'h0, -1, t, lat, rd);
      check("rd_98", rd[0], 32'hD0);
      check("rd_99", rd[1], 32'hD1);
      check("rd_0", rd[2], 32'hD2);
      check("rd_1", rd[3], 32'hD3);

      // Base address beyond DEPTH: first beat ignored by memory, then word 0.
      push_burst(0, 1'b1, 120, 1, 32'hE0, 2);
      burst(0, 1'b1, 120, 1, 32'hE0, -1, t, lat, rd);
      push_burst(0, 1'b0, 0, 0, 32'h0, 1);
      burst(0, 1'b0, 0, 0, 32'h0, -1, t, lat, rd);
      check("rd_wrap_base", rd[0], 32'hE1);

      // M1 drops req after the 2nd of 8 beats.
      push_burst(1, 1'b1, 20, 7, 32'hB0, 2);
      burst(1, 1'b1, 20, 7, 32'hB0, 2, t, lat, rd);
      @(negedge clk);
      check("drop_mem_we", mem_we, 1'b0);
      check("drop_ack", m_ack[1], 1'b0);
      check("drop_gnt_held", m_gnt[1], 1'b1);
      @(negedge clk);
      check("drop_gnt_next", m_gnt[1], 1'b0);
      @(posedge clk);
      #1;
      push_burst(0, 1'b0, 20, 3, 32'h0, 4);
      burst(0, 1'b0, 20, 3, 32'h0, -1, t, lat, rd);
      check("drop_rd_20", rd[0], 32'hB0);
      check("drop_rd_21", rd[1], 32'hB1);
      check("drop_rd_22", rd[2], 32'h0);
      check("drop_rd_23", rd[3], 32'h0);

      // Async reset during the 3rd of 4 write beats.
      push_burst(0, 1'b1, 40, 3, 32'hF0, 2);
      m_we[0] = 1'b1;
      m_addr[0] = 7'd40;
      m_len[0] = 4'd3;
      m_wdata[0] = 32'hF0;
      m_req[0] = 1'b1;
      acks = 0;
      n = 0;
      while (acks < 2 && n < 20) begin
         @(negedge clk);
         n++;
         if (m_ack[0]) begin
            acks++;
            @(posedge clk);
            #1;
            if (acks < 2) m_wdata[0] = 32'hF0 + 32'(acks);
         end
      end
      check("rst_mid_acks", acks, 2);
      rst = 1'b0;
      #1;
      check("rst_mid_gnt", m_gnt[0], 1'b0);
      check("rst_mid_ack", m_ack[0], 1'b0);
      check("rst_mid_mem_we", mem_we, 1'b0);
      m_req[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      // Single-beat reads after reset: ack and done together, 1-cycle grant.
      push_burst(0, 1'b0, 41, 0, 32'h0, 1);
      burst(0, 1'b0, 41, 0, 32'h0, -1, t, lat, rd);
      check("post_rst_lat", lat, 1);
      check("single_rd_41", rd[0], 32'hF1);
      push_burst(0, 1'b0, 42, 0, 32'h0, 1);
      burst(0, 1'b0, 42, 0, 32'h0, -1, t, lat, rd);
      check("aborted_beat_42", rd[0], 32'h0);

      repeat (3) @(negedge clk);
      check("exp_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (100 x 32-bit words, async read, sync write) between two requesters: M0 (processor load/store port) and M1 (loader/debug port for preloading and dumping memory).
- Grants one requester at a time for a burst of 1..16 consecutive word accesses.
- Generates the per-beat address internally and drives the memory's A/WD/we pins.
- Sits between the requesters and the data memory instance; the memory itself is unchanged.

Parameters:
- DEPTH, 100, number of memory words; burst addresses wrap at DEPTH.
- ADDR_W, 7, address width; must satisfy 2^ADDR_W >= DEPTH.
- LEN_W, 4, burst length field width; beats = len+1.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- m0_req  in  1  M0 burst request; hold high until m0_done
- m0_we  in  1  M0 burst direction: 1 = write, 0 = read
- m0_addr  in  ADDR_W  M0 burst base word address
- m0_len  in  LEN_W  M0 beats minus one
- m0_wdata  in  DATA_W  M0 write data for current beat
- m0_gnt  out  1  M0 owns memory
- m0_ack  out  1  M0 beat completed this cycle
- m0_done  out  1  M0 last beat completed this cycle
- m1_req, m1_we, m1_addr, m1_len, m1_wdata, m1_gnt, m1_ack, m1_done: same as M0, for M1
- rdata  out  DATA_W  read data, valid with the acking master's ack on a read beat
- mem_a  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rd  in  DATA_W  memory combinational read data

Behaviour:
- Reset (rst=0, async): state IDLE; all gnt/ack/done = 0; mem_we = 0; mem_a = 0; beat counter = 0; last-grant pointer = M1, so M0 wins the first tie.
- A reset asserted mid-burst aborts the burst immediately. Memory contents are not touched by the arbiter.
- States: IDLE, BURST.
- IDLE:
  - If any req is high, register the winner's addr into the address register, len into the remaining counter, and we into the direction flag.
  - Assert the winner's gnt from the next cycle and move to BURST.
  - No mem_we in IDLE.
- Arbitration: round-robin.
  - A single requester wins.
  - If both request, the requester not granted last wins.
  - The pointer updates on every grant.
- BURST: one beat per cycle, gnt held.
  - mem_a = address register.
  - mem_we = direction flag; mem_wd = owner's wdata.
  - Owner's ack = 1 each beat; rdata = mem_rd in the same cycle, 0 on write beats.
  - After each beat, the address increments, wrapping from DEPTH-1 to 0; remaining decrements.
- Last beat (remaining = 0):
  - Owner's done = 1 with ack.
  - Next cycle: gnt = 0, state IDLE.
  - Minimum one idle cycle between bursts, so grant latency from req is 1 cycle.
- Owner drops req mid-burst: the current cycle's beat is not performed. mem_we is forced 0 combinationally, with no ack and no done. Return to IDLE next cycle.
- Non-owner req is ignored until IDLE.
- The owner must present the next beat's wdata in the cycle after each ack.
- Base addr >= DEPTH: address is taken modulo-wrap to 0 at the first increment. The first beat uses the address as given, and the memory ignores out-of-range writes.
- Outputs gnt/ack/done are decoded from registered state plus owner req (ack/done gated by req).

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
  - Defined: M0 always wins ties (the processor must not starve); the round-robin pointer is removed.
  - Undefined: round-robin as above.
  - Single-requester behaviour is identical either way.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding constants IDLE=1'b0, BURST=1'b1;
  - master index constants M0=0, M1=1;
  - DEPTH/ADDR_W/LEN_W defaults.
- One natural sub-module, dmem_arb_pick: combinational winner selection from reqs and last pointer, with the macro applied there.
- Burst sequencing stays in the top.

Test Plan:
- M1 write burst, addr=5, len=3, wdata 0xA0..0xA3:
  - gnt 1 cycle after req;
  - mem_we/ack on 4 consecutive cycles with mem_a 5,6,7,8;
  - done on the 4th;
  - M0 read of 5..8 then returns 0xA0..0xA3 on rdata.
- Both req in the same cycle after reset:
  - M0 granted first, then M1 after one IDLE cycle;
  - next tie goes to M0 again (alternation).
  - With DMEM_ARB_FIXED_PRIO_EN, M0 wins every tie.
- Wrap: M0 write addr=98, len=3 -> mem_a 98,99,0,1; done on the 4th beat.
- Mid-burst drop: M1 write len=7, req low after the 2nd ack -> no mem_we that cycle; gnt=0 next cycle; only 2 words written.
- Async reset after the 2nd of 4 beats: gnt/ack/mem_we go 0 immediately without a clock; after release, a fresh M0 req is granted in 1 cycle.
- Single-beat read, len=0: ack and done in the same cycle, rdata = mem_rd at the given address.
